sysid_check_master: RTL



---
 rtl/sysid_check_pkg.sv | 25 ++
 rtl/sysid_check_timer.sv | 29 ++
 rtl/sysid_check_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
//   state_t           : check sequencer states
//   SYSID_ADDR_*      : word addresses inside the system-ID slave
//   SYSID_DEFAULT_*   : default expected ID / build timestamp
package sysid_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_ID = 3'd1,
        LAT_ID = 3'd2,
        REQ_TS = 3'd3,
        LAT_TS = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic        SYSID_ADDR_ID    = 1'b0;
    localparam logic        SYSID_ADDR_TS    = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1561603805;

    // Width of the shared latency / stall timer (TIMEOUT max is 65535).
    localparam int unsigned TMR_W            = 16;

endpackage

// File: rtl/sysid_check_timer.sv
// Loadable down-counter used for read latency, stall timeout and the
// optional re-check period.
//   clock, reset_n : clock, async active-low reset (count returns to INIT)
//   load, value    : load value into the counter (has priority over dec)
//   dec            : decrement by one, saturating at zero
//   count          : current count
module sysid_check_timer #(
    parameter int unsigned    W    = 16,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= INIT;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp) and compares both against expected values.
// Optional macro SYSID_CHECK_PERIODIC_EN adds periodic re-checks and the
// mismatch_sticky output.
//   clock, reset_n   : clock, async active-low reset
//   start            : one-cycle check request (ignored while busy)
//   avm_address/read : read master request to the sysid slave
//   avm_readdata     : slave read data
//   avm_waitrequest  : slave stall
//   busy, done       : check in progress / one-cycle completion pulse
//   id_ok, ts_ok     : captured values matched expected values
//   timeout_err      : a read stalled for TIMEOUT cycles
//   id_value/ts_value: last captured words
//   mismatch_sticky  : (optional) any failing check since reset
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS  = SYSID_DEFAULT_TS,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned AUTO_START   = 1,
    parameter int unsigned PERIOD       = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    output logic        mismatch_sticky
`endif
);

    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(READ_LATENCY);

    state_t             state_q, state_d;
    logic               first_q;
    logic               id_got_q, ts_got_q, id_got_d, ts_got_d;
    logic [31:0]        id_value_d, ts_value_d;
    logic               id_ok_d, ts_ok_d, tmo_d;
    logic               read_done_c, kick_c, period_start_c;
    logic               tmr_load, tmr_dec;
    logic [TMR_W-1:0]   tmr_value, tmr_count;

    // Stall timer while requesting, latency timer while waiting for data.
    sysid_check_timer #(.W(TMR_W), .INIT('0)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .value   (tmr_value),
        .count   (tmr_count)
    );

    // High only on the first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) first_q <= 1'b1;
        else          first_q <= 1'b0;
    end

    assign kick_c = start | ((AUTO_START != 0) & first_q) | period_start_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, captured data and flag updates.
    always_comb begin
        state_d     = state_q;
        id_value_d  = id_value;
        ts_value_d  = ts_value;
        id_ok_d     = id_ok;
        ts_ok_d     = ts_ok;
        tmo_d       = timeout_err;
        id_got_d    = id_got_q;
        ts_got_d    = ts_got_q;
        read_done_c = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_value   = TMO_LOAD;

        case (state_q)
            IDLE: begin
                if (kick_c) begin
                    state_d  = REQ_ID;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    tmo_d    = 1'b0;
                    id_got_d = 1'b0;
                    ts_got_d = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            REQ_ID, REQ_TS: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        read_done_c = 1'b1;
                    end else begin
                        state_d   = (state_q == REQ_ID) ? LAT_ID : LAT_TS;
                        tmr_load  = 1'b1;
                        tmr_value = LAT_LOAD;
                    end
                end else if (tmr_count <= TMR_W'(1)) begin
                    // Stall budget exhausted: skip any remaining read.
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            LAT_ID, LAT_TS: begin
                if (tmr_count <= TMR_W'(1)) read_done_c = 1'b1;
                else                        tmr_dec     = 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (read_done_c) begin
            if ((state_q == REQ_TS) || (state_q == LAT_TS)) begin
                ts_value_d = avm_readdata;
                ts_got_d   = 1'b1;
                state_d    = FINISH;
            end else begin
                id_value_d = avm_readdata;
                id_got_d   = 1'b1;
                state_d    = REQ_TS;
                tmr_load   = 1'b1;
                tmr_value  = TMO_LOAD;
            end
        end

        // Flags judged from the values as they will stand during FINISH.
        if (state_d == FINISH) begin
            id_ok_d = id_got_d && (id_value_d == EXPECTED_ID);
            ts_ok_d = ts_got_d && (ts_value_d == EXPECTED_TS);
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            id_got_q    <= 1'b0;
            ts_got_q    <= 1'b0;
        end else begin
            avm_read    <= (state_d == REQ_ID) || (state_d == REQ_TS);
            avm_address <= ((state_d == REQ_TS) || (state_d == LAT_TS)) ? SYSID_ADDR_TS
                                                                          : SYSID_ADDR_ID;
            busy        <= (state_d != IDLE);
            done        <= (state_d == FINISH);
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout_err <= tmo_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
            id_got_q    <= id_got_d;
            ts_got_q    <= ts_got_d;
        end
    end

`ifdef SYSID_CHECK_PERIODIC_EN
    localparam int unsigned      PERIOD_W    = 32;
    localparam logic [PERIOD_W-1:0] PER_LOAD = PERIOD_W'(PERIOD - 1);

    logic                per_load, per_dec;
    logic [PERIOD_W-1:0] per_count;

    // Remaining idle cycles before the next automatic check.
    sysid_check_timer #(.W(PERIOD_W), .INIT(PER_LOAD)) u_period (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (per_load),
        .dec     (per_dec),
        .value   (PER_LOAD),
        .count   (per_count)
    );

    always_comb begin
        per_load       = 1'b0;
        per_dec        = 1'b0;
        period_start_c = 1'b0;
        if (start) begin
            per_load = 1'b1;
        end else if (state_q == IDLE) begin
            if (per_count == '0) begin
                period_start_c = 1'b1;
                per_load       = 1'b1;
            end else begin
                per_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_sticky <= 1'b0;
        end else if ((state_d == FINISH) && (!id_ok_d || !ts_ok_d || tmo_d)) begin
            mismatch_sticky <= 1'b1;
        end
    end
`else
    // No periodic re-check in this build; PERIOD is referenced only here.
    assign period_start_c = 1'b0 & (PERIOD == 0);
`endif

endmodule
